alu_seq: RTL and testbench

Parametrised, handshaked successor to the core's combinational ALU. It registers every result and adds an iterative RV32M-style multiply/divide engine, so the execute stage can issue multi-cycle operations and stall on backpressure. Base ops complete in 1 cycle. Mul/div ops occupy the unit for WIDTH+2 cycles. It sits between operand select and writeback in the execute stage.

---
 rtl/alu_seq_pkg.sv | 53 +++++
 rtl/alu_muldiv_iter.sv | 167 ++++++++++++++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the sequential ALU.
//   ALU_OP_*   base operation codes carried in op[3:0] when op[4]=0
//   ALU_MD_*   multiply/divide codes carried in op[2:0] when op[4]=1
//   md_state_e multiply/divide sequencer states
//   cmp_flag() branch-flag selection for the compare group
package alu_seq_pkg;

    // Base ops. The compare group is the set with op[2:1]=2'b11 so that
    // {op[3],op[0]} directly selects eq/ne/ltu/geu.
    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0001;
    localparam logic [3:0] ALU_OP_AND = 4'b0010;
    localparam logic [3:0] ALU_OP_OR  = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR = 4'b0100;
    localparam logic [3:0] ALU_OP_SLL = 4'b0101;
    localparam logic [3:0] ALU_OP_EQ  = 4'b0110;
    localparam logic [3:0] ALU_OP_NE  = 4'b0111;
    localparam logic [3:0] ALU_OP_SRL = 4'b1000;
    localparam logic [3:0] ALU_OP_SRA = 4'b1001;
    localparam logic [3:0] ALU_OP_LTU = 4'b1110;
    localparam logic [3:0] ALU_OP_GEU = 4'b1111;

    // Multiply/divide ops, RV32M funct3 ordering.
    localparam logic [2:0] ALU_MD_MUL    = 3'b000;
    localparam logic [2:0] ALU_MD_MULH   = 3'b001;
    localparam logic [2:0] ALU_MD_MULHSU = 3'b010;
    localparam logic [2:0] ALU_MD_MULHU  = 3'b011;
    localparam logic [2:0] ALU_MD_DIV    = 3'b100;
    localparam logic [2:0] ALU_MD_DIVU   = 3'b101;
    localparam logic [2:0] ALU_MD_REM    = 3'b110;
    localparam logic [2:0] ALU_MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    // sel = {op[3], op[0]}: 00 eq, 01 ne, 10 unsigned lt, 11 unsigned ge
    function automatic logic cmp_flag(input logic [1:0] sel, input logic eq, input logic ltu);
        logic r;
        case (sel)
            2'b00:   r = eq;
            2'b01:   r = !eq;
            2'b10:   r = ltu;
            2'b11:   r = !ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply/divide engine for alu_seq.
//   start  accept a non-special mul/div (only honoured while idle)
//   md_op  ALU_MD_* code, a/b operands
//   busy   engine not idle
//   done   one-cycle pulse in the fix-up state; res is valid with it
//   res    signed-corrected result
// Multiply is shift-add over WIDTH steps into a 2*WIDTH product; divide
// is restoring division over WIDTH steps. Both work on magnitudes and
// the sign is restored in the FIX state.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_LOAD = SHAMT_W'(WIDTH-1);
    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};

    md_state_e          state_r, state_nxt_s;
    logic [SHAMT_W-1:0] cnt_r;
    logic [2*WIDTH-1:0] acc_r, acc_step_s, prod_s;
    logic [WIDTH-1:0]   opnd_r, mag_a_s, mag_b_s, sub_s, quo_s, remv_s, hi_s, lo_s;
    logic [WIDTH:0]     add_s, rem_sh_s;
    logic [2:0]         op_r;
    logic               neg_q_r, neg_r_r, sgn_a_s, sgn_b_s, neg_a_s, neg_b_s, ge_s;

    assign hi_s = acc_r[2*WIDTH-1:WIDTH];
    assign lo_s = acc_r[WIDTH-1:0];

    // Operand signedness and magnitudes for the op being accepted
    always_comb begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
        case (md_op)
            ALU_MD_MUL, ALU_MD_MULHU, ALU_MD_DIVU, ALU_MD_REMU: begin
                sgn_a_s = 1'b0;
                sgn_b_s = 1'b0;
            end
            ALU_MD_MULH, ALU_MD_DIV, ALU_MD_REM: begin
                sgn_a_s = 1'b1;
                sgn_b_s = 1'b1;
            end
            ALU_MD_MULHSU: begin
                sgn_a_s = 1'b1;
                sgn_b_s = 1'b0;
            end
            default: begin
                sgn_a_s = 1'b0;
                sgn_b_s = 1'b0;
            end
        endcase
        neg_a_s = sgn_a_s && a[WIDTH-1];
        neg_b_s = sgn_b_s && b[WIDTH-1];
        mag_a_s = neg_a_s ? (~a + ONE_W) : a;
        mag_b_s = neg_b_s ? (~b + ONE_W) : b;
    end

    // One iteration: acc holds {product-high, multiplier} or {remainder, quotient}
    always_comb begin
        add_s    = {1'b0, hi_s} + {1'b0, opnd_r};
        rem_sh_s = {hi_s, lo_s[WIDTH-1]};
        ge_s     = (rem_sh_s >= {1'b0, opnd_r});
        sub_s    = rem_sh_s[WIDTH-1:0] - opnd_r;
        if (op_r[2]) begin
            if (ge_s) begin
                acc_step_s = {sub_s, lo_s[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {rem_sh_s[WIDTH-1:0], lo_s[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_s[0]) begin
                acc_step_s = {add_s, lo_s[WIDTH-1:1]};
            end else begin
                acc_step_s = {1'b0, hi_s, lo_s[WIDTH-1:1]};
            end
        end
    end

    // Sequencer next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (start) begin
                    state_nxt_s = MD_CALC;
                end else begin
                    state_nxt_s = MD_IDLE;
                end
            end
            MD_CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = MD_FIX;
                end else begin
                    state_nxt_s = MD_CALC;
                end
            end
            MD_FIX:  state_nxt_s = MD_DONE;
            MD_DONE: state_nxt_s = MD_IDLE;
            default: state_nxt_s = MD_IDLE;
        endcase
    end

    // State, counter and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MD_IDLE;
            cnt_r   <= CNT_ZERO;
            acc_r   <= {(2*WIDTH){1'b0}};
            opnd_r  <= {WIDTH{1'b0}};
            op_r    <= 3'b000;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == MD_IDLE && start) begin
                cnt_r   <= CNT_LOAD;
                op_r    <= md_op;
                neg_q_r <= neg_a_s ^ neg_b_s;
                neg_r_r <= neg_a_s;
                if (md_op[2]) begin
                    acc_r  <= {{WIDTH{1'b0}}, mag_a_s};
                    opnd_r <= mag_b_s;
                end else begin
                    acc_r  <= {{WIDTH{1'b0}}, mag_b_s};
                    opnd_r <= mag_a_s;
                end
            end else if (state_r == MD_CALC) begin
                acc_r <= acc_step_s;
                if (cnt_r != CNT_ZERO) begin
                    cnt_r <= cnt_r - CNT_ONE;
                end
            end
        end
    end

    // Sign fix-up and result selection
    always_comb begin
        prod_s = neg_q_r ? (~acc_r + ONE_2W) : acc_r;
        quo_s  = neg_q_r ? (~lo_s + ONE_W) : lo_s;
        remv_s = neg_r_r ? (~hi_s + ONE_W) : hi_s;
        case (op_r)
            ALU_MD_MUL:                               res = prod_s[WIDTH-1:0];
            ALU_MD_MULH, ALU_MD_MULHSU, ALU_MD_MULHU: res = prod_s[2*WIDTH-1:WIDTH];
            ALU_MD_DIV, ALU_MD_DIVU:                  res = quo_s;
            ALU_MD_REM, ALU_MD_REMU:                  res = remv_s;
            default:                                  res = {WIDTH{1'b0}};
        endcase
    end

    assign busy = (state_r != MD_IDLE);
    assign done = (state_r == MD_FIX);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with optional iterative mul/div.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (op, a, b)
//   out_valid/out_ready result handshake (c, f, err)
//   c                   result; f compare flag; err unsupported op
// Build option: define ALU_MULDIV_EN to include the alu_muldiv_iter
// engine. Without it any op[4]=1 completes next cycle with err=1, c=0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             f,
    output logic             err
);

    logic               accept_s, busy_s, md_done_s, md_start_s, imm_load_s;
    logic               base_f_s, imm_f_s, imm_err_s;
    logic [WIDTH-1:0]   md_res_s, base_c_s, imm_c_s;
    logic [SHAMT_W-1:0] shamt_s;

    assign shamt_s  = b[SHAMT_W-1:0];
    // A result slot is free if empty or being drained this cycle.
    assign in_ready = !busy_s && (!out_valid || out_ready);
    assign accept_s = in_valid && in_ready;

    // Base (single-cycle) operations
    always_comb begin
        base_c_s = {WIDTH{1'b0}};
        base_f_s = 1'b0;
        case (op[3:0])
            ALU_OP_ADD: base_c_s = a + b;
            ALU_OP_SUB: base_c_s = a - b;
            ALU_OP_AND: base_c_s = a & b;
            ALU_OP_OR:  base_c_s = a | b;
            ALU_OP_XOR: base_c_s = a ^ b;
            ALU_OP_SLL: base_c_s = a << shamt_s;
            ALU_OP_SRL: base_c_s = a >> shamt_s;
            ALU_OP_SRA: base_c_s = $signed(a) >>> shamt_s;
            ALU_OP_EQ, ALU_OP_NE, ALU_OP_LTU, ALU_OP_GEU: begin
                base_c_s = a - b;
                base_f_s = cmp_flag({op[3], op[0]}, (a == b), (a < b));
            end
            default: begin
                base_c_s = {WIDTH{1'b0}};
                base_f_s = 1'b0;
            end
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             b_zero_s, ovf_s, special_s;
    logic [WIDTH-1:0] special_c_s;

    assign b_zero_s  = (b == {WIDTH{1'b0}});
    assign ovf_s     = ((op[2:0] == ALU_MD_DIV) || (op[2:0] == ALU_MD_REM)) &&
                       (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    // Divide-by-zero and signed overflow finish without iterating.
    assign special_s  = op[2] && (b_zero_s || ovf_s);
    assign md_start_s = accept_s && op[4] && !special_s;

    // Special-case results; op[1] distinguishes REM* from DIV*
    always_comb begin
        if (b_zero_s) begin
            if (op[1]) begin
                special_c_s = a;
            end else begin
                special_c_s = {WIDTH{1'b1}};
            end
        end else begin
            if (op[1]) begin
                special_c_s = {WIDTH{1'b0}};
            end else begin
                special_c_s = a;
            end
        end
    end

    // Result for anything that completes in one cycle
    always_comb begin
        if (op[4]) begin
            imm_c_s   = special_c_s;
            imm_f_s   = 1'b0;
            imm_err_s = 1'b0;
        end else begin
            imm_c_s   = base_c_s;
            imm_f_s   = base_f_s;
            imm_err_s = 1'b0;
        end
    end

    alu_muldiv_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start_s),
        .md_op (op[2:0]),
        .a     (a),
        .b     (b),
        .busy  (busy_s),
        .done  (md_done_s),
        .res   (md_res_s)
    );
`else
    assign busy_s     = 1'b0;
    assign md_done_s  = 1'b0;
    assign md_res_s   = {WIDTH{1'b0}};
    assign md_start_s = 1'b0;

    // Result for anything that completes in one cycle; mul/div is unsupported
    always_comb begin
        if (op[4]) begin
            imm_c_s   = {WIDTH{1'b0}};
            imm_f_s   = 1'b0;
            imm_err_s = 1'b1;
        end else begin
            imm_c_s   = base_c_s;
            imm_f_s   = base_f_s;
            imm_err_s = 1'b0;
        end
    end
`endif

    assign imm_load_s = accept_s && !md_start_s;

    // Single-entry output register; holds while out_valid && !out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= {WIDTH{1'b0}};
            f         <= 1'b0;
            err       <= 1'b0;
        end else if (md_done_s) begin
            out_valid <= 1'b1;
            c         <= md_res_s;
            f         <= 1'b0;
            err       <= 1'b0;
        end else if (imm_load_s) begin
            out_valid <= 1'b1;
            c         <= imm_c_s;
            f         <= imm_f_s;
            err       <= imm_err_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                           OP_OR  = 5'b00011, OP_XOR = 5'b00100, OP_SLL = 5'b00101,
                           OP_EQ  = 5'b00110, OP_NE  = 5'b00111, OP_SRL = 5'b01000,
                           OP_SRA = 5'b01001, OP_LTU = 5'b01110, OP_GEU = 5'b01111,
                           OP_BAD = 5'b01010;
    localparam logic [4:0] MD_MUL = 5'b10000, MD_MULH = 5'b10001, MD_MULHSU = 5'b10010,
                           MD_MULHU = 5'b10011, MD_DIV = 5'b10100, MD_DIVU = 5'b10101,
                           MD_REM = 5'b10110, MD_REMU = 5'b10111;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, f, err;
    logic [4:0]   op;
    logic [W-1:0] a, b, c;
    int           checks = 0;
    int           errors = 0;
    bit           md_on;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .f(f), .err(err)
    );

    // Reference model: results from plain 64-bit arithmetic.
    function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] ec, output logic ef, output logic ee,
                                  output int el);
        logic signed [63:0] sx, sy, sp;
        logic [63:0]        ux, uy, up;
        logic signed [31:0] xs, ys;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'h0, x};
        uy = {32'h0, y};
        xs = x;
        ys = y;
        ec = 32'h0; ef = 1'b0; ee = 1'b0; el = 1;
        if (!o[4]) begin
            case (o)
                OP_ADD: ec = x + y;
                OP_SUB: ec = x - y;
                OP_AND: ec = x & y;
                OP_OR:  ec = x | y;
                OP_XOR: ec = x ^ y;
                OP_SLL: ec = x << y[4:0];
                OP_SRL: ec = x >> y[4:0];
                OP_SRA: ec = xs >>> y[4:0];
                OP_EQ:  begin ec = x - y; ef = (x == y); end
                OP_NE:  begin ec = x - y; ef = (x != y); end
                OP_LTU: begin ec = x - y; ef = (x < y);  end
                OP_GEU: begin ec = x - y; ef = (x >= y); end
                default: ec = 32'h0;
            endcase
        end else if (!md_on) begin
            ee = 1'b1;
        end else begin
            case (o)
                MD_MUL:    begin up = ux * uy; ec = up[31:0];  el = W + 2; end
                MD_MULH:   begin sp = sx * sy; ec = sp[63:32]; el = W + 2; end
                MD_MULHSU: begin sp = sx * $signed(uy); ec = sp[63:32]; el = W + 2; end
                MD_MULHU:  begin up = ux * uy; ec = up[63:32]; el = W + 2; end
                MD_DIV: begin
                    if (y == 32'h0) ec = 32'hFFFF_FFFF;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ec = x;
                    else begin ec = xs / ys; el = W + 2; end
                end
                MD_DIVU: begin
                    if (y == 32'h0) ec = 32'hFFFF_FFFF;
                    else begin ec = x / y; el = W + 2; end
                end
                MD_REM: begin
                    if (y == 32'h0) ec = x;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ec = 32'h0;
                    else begin ec = xs % ys; el = W + 2; end
                end
                default: begin
                    if (y == 32'h0) ec = x;
                    else begin ec = x % y; el = W + 2; end
                end
            endcase
        end
    endfunction

    // Issue one op with out_ready=1, wait (bounded) for its result.
    // Starts and ends just after a rising edge.
    task automatic send_wait(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] oc, output logic of, output logic oe,
                             output int lat, output bit early_ready);
        int n;
        out_ready = 1'b1; op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        early_ready = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) early_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        oc = c; of = f; oe = err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 5'h0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (c !== 32'h0) begin errors++; $display("FAIL reset_c: got %h want 0", c); end
        checks++; if ({f, err} !== 2'b00) begin errors++; $display("FAIL reset_f_err: got %b want 00", {f, err}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; op = OP_SRA; a = 32'h8000_0000; b = 32'h4; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
        @(posedge clk);
        #1 op = OP_ADD; a = 32'h1; b = 32'h2;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || c !== 32'hF800_0000) begin
            errors++; $display("FAIL b2b_sra: got v=%b c=%h want v=1 c=f8000000", out_valid, c); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || c !== 32'h3 || f !== 1'b0) begin
            errors++; $display("FAIL b2b_add: got v=%b c=%h f=%b want v=1 c=3 f=0", out_valid, c, f); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_compare_backpressure();
        int n;
        out_ready = 1'b0; op = OP_EQ; a = 32'h3; b = 32'h3; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 op = OP_LTU; a = 32'h1; b = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || c !== 32'h0 || f !== 1'b1) begin
                errors++; $display("FAIL hold_eq[%0d]: got v=%b c=%h f=%b want v=1 c=0 f=1", i, out_valid, c, f); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || c !== 32'h2 || f !== 1'b1) begin
            errors++; $display("FAIL ltu: got v=%b c=%h f=%b want v=1 c=2 f=1", out_valid, c, f); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ltu_drain: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_muldiv();
        logic [4:0]  t_op [9];
        logic [31:0] t_a [9], t_b [9], t_c [9];
        int          t_l [9];
        logic [31:0] oc, ec;
        logic        of, oe, ee;
        int          lat, el;
        bit          er;
        t_op = '{MD_MULHU, MD_MUL, MD_MULH, MD_DIV, MD_REM, MD_DIVU, MD_REMU, MD_DIV, MD_REM};
        t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                 32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000};
        t_b  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2,
                 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_c  = '{32'hFFFF_FFFE, 32'h1, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0};
        t_l  = '{34, 34, 34, 34, 34, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            ec = md_on ? t_c[i] : 32'h0;
            el = md_on ? t_l[i] : 1;
            ee = !md_on;
            send_wait(t_op[i], t_a[i], t_b[i], oc, of, oe, lat, er);
            checks++; if (oc !== ec || of !== 1'b0 || oe !== ee) begin
                errors++; $display("FAIL md_dir[%0d]: got c=%h f=%b err=%b want c=%h f=0 err=%b", i, oc, of, oe, ec, ee); end
            checks++; if (lat !== el || er !== 1'b0) begin
                errors++; $display("FAIL md_lat[%0d]: got lat=%0d early_ready=%b want lat=%0d early_ready=0", i, lat, er, el); end
        end
    endtask

    task automatic test_reset_mid();
        int n, seen;
        logic [31:0] oc;
        logic        of, oe;
        int          lat;
        bit          er;
        out_ready = 1'b0; op = MD_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_ghost: got %0d valid cycles want 0", seen); end
        @(posedge clk);
        #1;
        send_wait(OP_XOR, 32'hF0F0_1234, 32'h0FF0_4321, oc, of, oe, lat, er);
        checks++; if (oc !== 32'hFF00_5115 || lat !== 1) begin
            errors++; $display("FAIL rst_after: got c=%h lat=%0d want c=ff005115 lat=1", oc, lat); end
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 40);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [4:0]  ops [21];
        logic [4:0]  o;
        logic [31:0] x, y, oc, ec;
        logic        of, oe, ef, ee;
        int          lat, el;
        bit          er;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_EQ, OP_NE,
                OP_LTU, OP_GEU, OP_BAD, MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV,
                MD_DIVU, MD_REM, MD_REMU};
        for (int i = 0; i < 60; i++) begin
            o = ops[$urandom_range(0, 20)];
            x = pick_val();
            y = pick_val();
            if (o == OP_EQ && $urandom_range(0, 1) == 1) y = x;
            model(o, x, y, ec, ef, ee, el);
            send_wait(o, x, y, oc, of, oe, lat, er);
            checks++; if (oc !== ec || of !== ef || oe !== ee) begin
                errors++; $display("FAIL rand[%0d] op=%b a=%h b=%h: got c=%h f=%b err=%b want c=%h f=%b err=%b",
                                   i, o, x, y, oc, of, oe, ec, ef, ee); end
            checks++; if (lat !== el || er !== 1'b0) begin
                errors++; $display("FAIL rand_lat[%0d] op=%b: got lat=%0d early_ready=%b want lat=%0d early_ready=0",
                                   i, o, lat, er, el); end
        end
    endtask

    initial begin
`ifdef ALU_MULDIV_EN
        md_on = 1'b1;
`else
        md_on = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_compare_backpressure();
        test_muldiv();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
